i2c_apb_cfg_arbiter: RTL
========================

// Module: i2c_apb_cfg_arbiter
// PURPOSE
//  APB master that shares one APB port of the I2C register block between two requesters (0 = host, 1 = sequencer).
//  Arbitrates round-robin and runs a SETUP/ACCESS APB cycle with PREADY wait states.
//  Returns read data, plus an error flag on timeout.
//  Sits between the config clients and the register block's PSEL/PENABLE/PADDR/PWDATA/PWRITE/PRDATA/PREADY.
// PARAMETERS
//  ADDR_W   8   APB address width
//  DATA_W   8   APB data width
//  TIMEOUT  16  max ACCESS cycles waiting for PREADY_i before abort; 0 = never time out
// PORTS
//  PCLK_i        in   1          clock, rising edge
//  PRESET_i      in   1          asynchronous reset, active-high
//  REQ_VALID_i   in   2          per-requester transfer request; hold with fields stable until REQ_ACK_o
//  REQ_WRITE_i   in   2          per-requester 1 = write, 0 = read
//  REQ_ADDR_i    in   2*ADDR_W   [ADDR_W-1:0] = req0, upper slice = req1
//  REQ_WDATA_i   in   2*DATA_W   [DATA_W-1:0] = req0, upper slice = req1
//  REQ_ACK_o     out  2          one-cycle pulse: request captured
//  RSP_VALID_o   out  2          one-cycle pulse: transfer finished for that requester
//  RSP_RDATA_o   out  DATA_W     read data; valid with RSP_VALID_o; 0 for writes and errors
//  RSP_ERR_o     out  1          valid with RSP_VALID_o; 1 = timeout abort
//  PSEL_o        out  1          APB select
//  PENABLE_o     out  1          APB enable
//  PWRITE_o      out  1          APB direction
//  PADDR_o       out  ADDR_W     APB address
//  PWDATA_o      out  DATA_W     APB write data
//  PRDATA_i      in   DATA_W     APB read data
//  PREADY_i      in   1          APB ready
// BEHAVIOUR
//  Reset values: all outputs are registered and reset to 0. Internal state: FSM = IDLE, last_grant = 1 (req0 wins first), timeout count = 0.
//  Reset mid-transfer drops PSEL_o and PENABLE_o asynchronously. The in-flight transfer is discarded, with no RSP_VALID_o.
//  FSM states: IDLE -> SETUP -> ACCESS -> IDLE.
//  IDLE:
//    - Any REQ_VALID_i set -> grant and go to SETUP.
//    - Grant: the single valid requester, or, if both are valid, the one that is not last_grant.
//    - Latch WRITE/ADDR/WDATA of the granted requester into PWRITE_o/PADDR_o/PWDATA_o.
//    - Update last_grant.
//  SETUP (exactly 1 cycle): PSEL_o=1, PENABLE_o=0; REQ_ACK_o[grant]=1 this cycle only; next state ACCESS.
//  ACCESS: PSEL_o=1, PENABLE_o=1; PADDR/PWDATA/PWRITE held stable.
//    - PREADY_i=1 -> complete: reads capture PRDATA_i; writes return 0.
//    - PREADY_i=0 -> stay and count.
//    - If TIMEOUT!=0 and the count reaches TIMEOUT with PREADY_i still 0 -> abort with error, RDATA = 0.
//  Complete/abort -> IDLE. In that IDLE cycle: PSEL_o=0, PENABLE_o=0, RSP_VALID_o[grant]=1 for one cycle, plus RSP_RDATA_o and RSP_ERR_o.
//  PWRITE_o/PADDR_o/PWDATA_o hold their last values outside transfers.
//  Latency with zero wait states:
//    - IDLE sample at edge N; SETUP N+1; ACCESS N+2; response N+3.
//    - Next grant can be sampled in that same response cycle, giving 3 cycles per transfer.
//  Registered ACK: a requester drops VALID after seeing ACK. IDLE is at least 2 cycles away, so one request cannot be granted twice.
//  RSP_VALID_o is one-hot or 0. REQ_ACK_o is one-hot or 0.
//  Timeout count: width is clog2(TIMEOUT+1). It clears on entry to ACCESS.
//  Requests arriving in SETUP/ACCESS wait; no queueing beyond the inputs.
//  APB protocol: PENABLE_o never rises without PSEL_o being high for the previous cycle. The FSM never skips SETUP.
// TESTING
//  1 Reset held, toggle all inputs -> every output 0; release reset, no requests -> bus stays idle.
//  2 req0 write 0x02/0xAB, PREADY_i=1:
//      - SETUP: PSEL=1, PENABLE=0, PADDR=02, PWDATA=AB, PWRITE=1, REQ_ACK=01.
//      - Next cycle: PENABLE=1.
//      - Next cycle: RSP_VALID=01, ERR=0.
//  3 Then req1 reads 0x02 from a register-block model -> RSP_VALID=10, RSP_RDATA=AB, ERR=0.
//  4 Both VALID from reset, each re-requests after its RSP -> grants 0,1,0,1; no requester starves.
//  5 PREADY_i low for 3 cycles in ACCESS -> PENABLE high 4 cycles; PADDR/PWDATA stable; single RSP_VALID pulse.
//  6 PREADY_i stuck 0, TIMEOUT=16 -> ACCESS lasts 16 cycles, then RSP_ERR=1, RSP_RDATA=00, PSEL=0.
//  7 PRESET_i pulsed mid-ACCESS -> PSEL/PENABLE 0 without a clock edge, no RSP_VALID; next request completes normally.

Source files
------------

// File: rtl/i2c_apb_cfg_arbiter.sv
// ---------------------------------------------------------------------------
// i2c_apb_cfg_arbiter
//   Shares the single APB slave port of the I2C register block between two
//   configuration clients (0 = host, 1 = sequencer). Requests are arbitrated
//   round-robin; each granted request runs one APB SETUP/ACCESS cycle,
//   honouring PREADY wait states, with an optional timeout abort.
//
// Ports
//   PCLK_i, PRESET_i       clock (rising edge), asynchronous active-high reset
//   REQ_VALID_i[1:0]       per-client request, held until REQ_ACK_o
//   REQ_WRITE_i[1:0]       per-client direction (1 = write)
//   REQ_ADDR_i / WDATA_i   packed per-client address / write data (req1 high)
//   REQ_ACK_o[1:0]         one-cycle pulse when a request is captured
//   RSP_VALID_o[1:0]       one-cycle pulse when that client's transfer ends
//   RSP_RDATA_o, RSP_ERR_o read data (0 for writes/errors), timeout flag
//   PSEL_o .. PWDATA_o     APB master outputs
//   PRDATA_i, PREADY_i     APB slave responses
// ---------------------------------------------------------------------------
module i2c_apb_cfg_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                PCLK_i,
    input  logic                PRESET_i,
    input  logic [1:0]          REQ_VALID_i,
    input  logic [1:0]          REQ_WRITE_i,
    input  logic [2*ADDR_W-1:0] REQ_ADDR_i,
    input  logic [2*DATA_W-1:0] REQ_WDATA_i,
    output logic [1:0]          REQ_ACK_o,
    output logic [1:0]          RSP_VALID_o,
    output logic [DATA_W-1:0]   RSP_RDATA_o,
    output logic                RSP_ERR_o,
    output logic                PSEL_o,
    output logic                PENABLE_o,
    output logic                PWRITE_o,
    output logic [ADDR_W-1:0]   PADDR_o,
    output logic [DATA_W-1:0]   PWDATA_o,
    input  logic [DATA_W-1:0]   PRDATA_i,
    input  logic                PREADY_i
);

    // A zero TIMEOUT still needs a legal (unused) counter width.
    localparam int CNT_W   = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam int TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [CNT_W-1:0] TO_LAST_C = CNT_W'(TO_LAST);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS
    } state_t;

    state_t              state_q;
    logic                last_grant_q;
    logic                grant_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [1:0]          ack_q;
    logic [1:0]          rsp_valid_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic                rsp_err_q;
    logic                psel_q;
    logic                penable_q;
    logic                pwrite_q;
    logic [ADDR_W-1:0]   paddr_q;
    logic [DATA_W-1:0]   pwdata_q;

    logic                grant_d;
    logic                timeout_hit;

    // Round-robin: on contention the client that did not win last time wins.
    always_comb begin
        grant_d = REQ_VALID_i[1];
        if (REQ_VALID_i == 2'b11) begin
            grant_d = ~last_grant_q;
        end
    end

    // This is the TIMEOUT-th consecutive ACCESS cycle without PREADY.
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST_C);

    always_ff @(posedge PCLK_i or posedge PRESET_i) begin
        if (PRESET_i) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            cnt_q        <= '0;
            ack_q        <= 2'b00;
            rsp_valid_q  <= 2'b00;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
        end else begin
            ack_q       <= 2'b00;
            rsp_valid_q <= 2'b00;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            case (state_q)
                // Arbitration: capture the winner's fields and open SETUP.
                S_IDLE: begin
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                    if (REQ_VALID_i != 2'b00) begin
                        grant_q      <= grant_d;
                        last_grant_q <= grant_d;
                        pwrite_q     <= REQ_WRITE_i[grant_d];
                        paddr_q      <= grant_d ? REQ_ADDR_i[2*ADDR_W-1:ADDR_W]
                                                : REQ_ADDR_i[ADDR_W-1:0];
                        pwdata_q     <= grant_d ? REQ_WDATA_i[2*DATA_W-1:DATA_W]
                                                : REQ_WDATA_i[DATA_W-1:0];
                        psel_q       <= 1'b1;
                        ack_q        <= {grant_d, ~grant_d};
                        state_q      <= S_SETUP;
                    end
                end
                // SETUP -> ACCESS: raise PENABLE, restart the wait counter.
                S_SETUP: begin
                    penable_q <= 1'b1;
                    cnt_q     <= '0;
                    state_q   <= S_ACCESS;
                end
                // ACCESS -> response: complete on PREADY, or abort on timeout.
                S_ACCESS: begin
                    if (PREADY_i || timeout_hit) begin
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= {grant_q, ~grant_q};
                        rsp_err_q   <= ~PREADY_i;
                        if (PREADY_i && !pwrite_q) begin
                            rsp_rdata_q <= PRDATA_i;
                        end
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

    assign REQ_ACK_o   = ack_q;
    assign RSP_VALID_o = rsp_valid_q;
    assign RSP_RDATA_o = rsp_rdata_q;
    assign RSP_ERR_o   = rsp_err_q;
    assign PSEL_o      = psel_q;
    assign PENABLE_o   = penable_q;
    assign PWRITE_o    = pwrite_q;
    assign PADDR_o     = paddr_q;
    assign PWDATA_o    = pwdata_q;

endmodule
